// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IC_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Reserved size 2'b11 is treated as a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Serialises one 1/2/4-byte access onto the byte-wide RAM port: address stepping,
// little-endian read assembly, write byte select, IO back-pressure stall and done.
module mem_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int          MEM_LAT = 1,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        start_we,
  input  logic [31:0] start_addr,
  input  logic [2:0]  start_n,
  input  logic [31:0] start_wdata,
  input  logic [7:0]  mem_din,
  input  logic        io_buffer_full,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  output logic [31:0] rdata_next,
  output logic        done
);

  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [31:0]       base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        ck_q, ck_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [MEM_LAT:0]  pipe_q, pipe_d;
  logic [31:0]       mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic              iss_en;
  logic              iss_we;
  logic [31:0]       iss_base;
  logic [2:0]        iss_k;
  logic [31:0]       iss_wdata;
  logic [31:0]       iss_addr;
  logic [7:0]        iss_byte;
  logic              stall;

  always_comb begin
    busy_d     = busy_q;
    we_d       = we_q;
    base_d     = base_q;
    n_d        = n_q;
    k_d        = k_q;
    ck_d       = ck_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    pipe_d     = {pipe_q[MEM_LAT-1:0], 1'b0};
    mem_a_d    = '0;
    mem_dout_d = '0;
    mem_wr_d   = 1'b0;
    rdata_next = rdata_q;
    done       = 1'b0;
    iss_en     = 1'b0;
    iss_we     = we_q;
    iss_base   = base_q;
    iss_k      = k_q;
    iss_wdata  = wdata_q;
    iss_byte   = '0;
    stall      = 1'b0;

    // Byte 0 is issued on the grant edge so the address appears in cycle 1.
    if (start) begin
      busy_d    = 1'b1;
      we_d      = start_we;
      base_d    = start_addr;
      n_d       = start_n;
      wdata_d   = start_wdata;
      rdata_d   = '0;
      ck_d      = '0;
      k_d       = '0;
      iss_en    = 1'b1;
      iss_we    = start_we;
      iss_base  = start_addr;
      iss_k     = '0;
      iss_wdata = start_wdata;
    end else if (busy_q && (k_q < n_q)) begin
      iss_en = 1'b1;
    end

    iss_addr = iss_base + {29'd0, iss_k};
    case (iss_k[1:0])
      2'd0:    iss_byte = iss_wdata[7:0];
      2'd1:    iss_byte = iss_wdata[15:8];
      2'd2:    iss_byte = iss_wdata[23:16];
      default: iss_byte = iss_wdata[31:24];
    endcase

    if (iss_en) begin
      mem_a_d = iss_addr;
      if (iss_we) begin
        // io_buffer_full is sampled one cycle ahead of the strobe it gates.
        stall      = io_buffer_full && (iss_addr >= IO_BASE);
        mem_dout_d = iss_byte;
        mem_wr_d   = !stall;
        if (!stall) k_d = iss_k + 3'd1;
      end else begin
        pipe_d[0] = 1'b1;
        k_d       = iss_k + 3'd1;
      end
    end

    if (busy_q && !we_q && pipe_q[MEM_LAT]) begin
      rdata_next[{ck_q[1:0], 3'b000} +: 8] = mem_din;
      rdata_d = rdata_next;
      ck_d    = ck_q + 3'd1;
      if (ck_q == n_q - 3'd1) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end

    if (busy_q && we_q && (k_q == n_q)) begin
      done   = 1'b1;
      busy_d = 1'b0;
    end

    if (abort) begin
      busy_d     = 1'b0;
      pipe_d     = '0;
      mem_a_d    = '0;
      mem_dout_d = '0;
      mem_wr_d   = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      base_q     <= '0;
      n_q        <= '0;
      k_q        <= '0;
      ck_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      pipe_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      we_q       <= we_d;
      base_q     <= base_d;
      n_q        <= n_d;
      k_q        <= k_d;
      ck_q       <= ck_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      pipe_q     <= pipe_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: rtl/mem_ctrl.sv
// Shares the byte-wide RAM port between instruction fetch and the load/store buffer.
// Define MEM_CTRL_RR_EN for round-robin arbitration; default is fixed LSB priority.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          MEM_LAT = 1,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_data,
  output logic        ic_valid,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic [31:0] lsb_rdata,
  output logic        lsb_valid,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state_q, state_d;
  logic        ic_pend_q, ic_pend_d;
  logic [31:0] ic_addr_q, ic_addr_d;
  logic        lsb_pend_q, lsb_pend_d;
  logic        lsb_we_q, lsb_we_d;
  logic [1:0]  lsb_size_q, lsb_size_d;
  logic [31:0] lsb_addr_q, lsb_addr_d;
  logic [31:0] lsb_wdata_q, lsb_wdata_d;
  logic [31:0] ic_data_q, ic_data_d;
  logic        ic_valid_q, ic_valid_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic        lsb_valid_q, lsb_valid_d;
`ifdef MEM_CTRL_RR_EN
  logic        last_lsb_q, last_lsb_d;
`endif

  logic        ic_avail, lsb_avail, grant_lsb;
  logic [31:0] ic_cur_addr, lsb_cur_addr, lsb_cur_wdata;
  logic        lsb_cur_we;
  logic [1:0]  lsb_cur_size;
  logic        start, abort, start_we, done;
  logic [31:0] start_addr, start_wdata, rdata_next;
  logic [2:0]  start_n;

  // A request pulse is granted on its own edge when idle, before it lands in pending.
  assign ic_avail      = (ic_pend_q || ic_req) && !flush;
  assign lsb_avail     = lsb_pend_q || lsb_req;
  assign ic_cur_addr   = ic_pend_q  ? ic_addr_q   : ic_addr;
  assign lsb_cur_we    = lsb_pend_q ? lsb_we_q    : lsb_we;
  assign lsb_cur_size  = lsb_pend_q ? lsb_size_q  : lsb_size;
  assign lsb_cur_addr  = lsb_pend_q ? lsb_addr_q  : lsb_addr;
  assign lsb_cur_wdata = lsb_pend_q ? lsb_wdata_q : lsb_wdata;

  always_comb begin
    state_d     = state_q;
    ic_pend_d   = ic_pend_q;
    ic_addr_d   = ic_addr_q;
    lsb_pend_d  = lsb_pend_q;
    lsb_we_d    = lsb_we_q;
    lsb_size_d  = lsb_size_q;
    lsb_addr_d  = lsb_addr_q;
    lsb_wdata_d = lsb_wdata_q;
    ic_data_d   = ic_data_q;
    ic_valid_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    lsb_valid_d = 1'b0;
`ifdef MEM_CTRL_RR_EN
    last_lsb_d  = last_lsb_q;
`endif
    grant_lsb   = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    start_we    = 1'b0;
    start_addr  = '0;
    start_n     = '0;
    start_wdata = '0;

    if (done && (state_q == IC_RD)) ic_pend_d = 1'b0;
    if (ic_req) begin
      ic_pend_d = 1'b1;
      ic_addr_d = ic_addr;
    end
    if (flush) ic_pend_d = 1'b0;

    if (done && ((state_q == LS_RD) || (state_q == LS_WR))) lsb_pend_d = 1'b0;
    if (lsb_req) begin
      lsb_pend_d  = 1'b1;
      lsb_we_d    = lsb_we;
      lsb_size_d  = lsb_size;
      lsb_addr_d  = lsb_addr;
      lsb_wdata_d = lsb_wdata;
    end

    case (state_q)
      IDLE: begin
        if (lsb_avail || ic_avail) begin
`ifdef MEM_CTRL_RR_EN
          grant_lsb  = lsb_avail && (!ic_avail || !last_lsb_q);
          last_lsb_d = grant_lsb;
`else
          grant_lsb  = lsb_avail;
`endif
          start = 1'b1;
          if (grant_lsb) begin
            start_we    = lsb_cur_we;
            start_addr  = lsb_cur_addr;
            start_n     = byte_count(lsb_cur_size);
            start_wdata = lsb_cur_wdata;
            state_d     = lsb_cur_we ? LS_WR : LS_RD;
          end else begin
            start_addr  = ic_cur_addr;
            start_n     = byte_count(SIZE_WORD);
            state_d     = IC_RD;
          end
        end
      end
      IC_RD: begin
        if (flush) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (done) begin
          ic_valid_d = 1'b1;
          ic_data_d  = rdata_next;
          state_d    = IDLE;
        end
      end
      LS_RD: begin
        if (done) begin
          lsb_valid_d = 1'b1;
          lsb_rdata_d = rdata_next;
          state_d     = IDLE;
        end
      end
      LS_WR: begin
        if (done) begin
          lsb_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ic_pend_q   <= 1'b0;
      ic_addr_q   <= '0;
      lsb_pend_q  <= 1'b0;
      lsb_we_q    <= 1'b0;
      lsb_size_q  <= '0;
      lsb_addr_q  <= '0;
      lsb_wdata_q <= '0;
      ic_data_q   <= '0;
      ic_valid_q  <= 1'b0;
      lsb_rdata_q <= '0;
      lsb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ic_pend_q   <= ic_pend_d;
      ic_addr_q   <= ic_addr_d;
      lsb_pend_q  <= lsb_pend_d;
      lsb_we_q    <= lsb_we_d;
      lsb_size_q  <= lsb_size_d;
      lsb_addr_q  <= lsb_addr_d;
      lsb_wdata_q <= lsb_wdata_d;
      ic_data_q   <= ic_data_d;
      ic_valid_q  <= ic_valid_d;
      lsb_rdata_q <= lsb_rdata_d;
      lsb_valid_q <= lsb_valid_d;
    end
  end

`ifdef MEM_CTRL_RR_EN
  // Reset to "IC last" so the first tie goes to the LSB, matching fixed priority.
  always_ff @(posedge clk) begin
    if (rst) last_lsb_q <= 1'b0;
    else     last_lsb_q <= last_lsb_d;
  end
`endif

  mem_byte_seq #(
    .MEM_LAT(MEM_LAT),
    .IO_BASE(IO_BASE)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .start_we      (start_we),
    .start_addr    (start_addr),
    .start_n       (start_n),
    .start_wdata   (start_wdata),
    .mem_din       (mem_din),
    .io_buffer_full(io_buffer_full),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .rdata_next    (rdata_next),
    .done          (done)
  );

  assign ic_data   = ic_data_q;
  assign ic_valid  = ic_valid_q;
  assign lsb_rdata = lsb_rdata_q;
  assign lsb_valid = lsb_valid_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        ic_req;
  logic [31:0] ic_addr, ic_data;
  logic        ic_valid;
  logic        lsb_req, lsb_we;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic        lsb_valid;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_valid(ic_valid),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata), .lsb_valid(lsb_valid),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= rst ? 8'h00 : ram_rd(mem_a);
  end

  // Per-cycle observations; index = cycles since the request edge.
  logic [31:0] o_a   [0:31];
  logic        o_wr  [0:31];
  logic [7:0]  o_do  [0:31];
  logic        o_icv [0:31];
  logic        o_lsv [0:31];
  logic [31:0] o_icd [0:31];
  logic [31:0] o_lsd [0:31];
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic begin_seq();
    cyc = 0;
    for (int i = 0; i < 32; i++) begin
      o_a[i] = '0; o_wr[i] = 1'b0; o_do[i] = '0; o_icv[i] = 1'b0;
      o_lsv[i] = 1'b0; o_icd[i] = '0; o_lsd[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cyc < 31) cyc++;
    o_a[cyc]   = mem_a;
    o_wr[cyc]  = mem_wr;
    o_do[cyc]  = mem_dout;
    o_icv[cyc] = ic_valid;
    o_lsv[cyc] = lsb_valid;
    o_icd[cyc] = ic_data;
    o_lsd[cyc] = lsb_rdata;
  endtask

  function automatic int first_ic();
    for (int c = 1; c <= cyc; c++) if (o_icv[c]) return c;
    return -1;
  endfunction
  function automatic int first_ls();
    for (int c = 1; c <= cyc; c++) if (o_lsv[c]) return c;
    return -1;
  endfunction
  function automatic int cnt_ic();
    int n = 0;
    for (int c = 1; c <= cyc; c++) if (o_icv[c]) n++;
    return n;
  endfunction
  function automatic int cnt_wr();
    int n = 0;
    for (int c = 1; c <= cyc; c++) if (o_wr[c]) n++;
    return n;
  endfunction

  task automatic lsb_issue(input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
    lsb_req = 1'b1; lsb_we = we; lsb_size = sz; lsb_addr = a; lsb_wdata = wd;
  endtask

  task automatic idle_inputs();
    ic_req = 1'b0; ic_addr = '0; lsb_req = 1'b0; lsb_we = 1'b0;
    lsb_size = '0; lsb_addr = '0; lsb_wdata = '0; flush = 1'b0;
  endtask

  logic [7:0] wb [0:3];

  initial begin
    rst = 1'b1; io_buffer_full = 1'b0;
    idle_inputs();
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
    ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2003] = 8'hF0; ram[32'h2004] = 8'hAA;
    wb[0] = 8'hEF; wb[1] = 8'hBE; wb[2] = 8'hAD; wb[3] = 8'hDE;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ic_valid", 32'(ic_valid), 0);
    chk("rst_lsb_valid", 32'(lsb_valid), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    chk("rst_ic_data", ic_data, 0);
    chk("rst_lsb_rdata", lsb_rdata, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Instruction fetch of 0x1000.
    begin_seq();
    ic_req = 1'b1; ic_addr = 32'h1000;
    step(); idle_inputs();
    repeat (7) step();
    for (int c = 1; c <= 4; c++) chk($sformatf("t1_mem_a_c%0d", c), o_a[c], 32'h1000 + c - 1);
    chk("t1_writes", cnt_wr(), 0);
    chk("t1_ic_valid_cyc", first_ic(), 6);
    chk("t1_ic_valid_cnt", cnt_ic(), 1);
    chk("t1_ic_data", o_icd[6], 32'h0000_0513);
    chk("t1_idle_mem_a", o_a[7], 0);
    chk("t1_lsb_quiet", first_ls(), -1);

    // Byte load of 0x2003.
    begin_seq();
    lsb_issue(1'b0, 2'b00, 32'h2003, 32'h0);
    step(); idle_inputs();
    repeat (4) step();
    chk("t2_mem_a", o_a[1], 32'h2003);
    chk("t2_valid_cyc", first_ls(), 3);
    chk("t2_rdata", o_lsd[3], 32'h0000_00F0);

    // Misaligned halfword load at 0x2003.
    begin_seq();
    lsb_issue(1'b0, 2'b01, 32'h2003, 32'h0);
    step(); idle_inputs();
    repeat (5) step();
    chk("t2h_mem_a2", o_a[2], 32'h2004);
    chk("t2h_valid_cyc", first_ls(), 4);
    chk("t2h_rdata", o_lsd[4], 32'h0000_AAF0);

    // Word store below IO_BASE; io_buffer_full must not stall it.
    begin_seq();
    io_buffer_full = 1'b1;
    lsb_issue(1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF);
    step(); idle_inputs();
    repeat (6) step();
    io_buffer_full = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t3_mem_a_c%0d", c), o_a[c], 32'h100 + c - 1);
      chk($sformatf("t3_mem_wr_c%0d", c), 32'(o_wr[c]), 1);
      chk($sformatf("t3_dout_c%0d", c), 32'(o_do[c]), 32'(wb[c-1]));
    end
    chk("t3_write_cnt", cnt_wr(), 4);
    chk("t3_valid_cyc", first_ls(), 5);
    chk("t3_ram_103", 32'(ram_rd(32'h103)), 32'hDE);

    // Simultaneous IC and LSB requests.
    begin_seq();
    ic_req = 1'b1; ic_addr = 32'h1000;
    lsb_issue(1'b0, 2'b00, 32'h2003, 32'h0);
    step(); idle_inputs();
    repeat (10) step();
`ifdef MEM_CTRL_RR_EN
    chk("t4_first_a", o_a[1], 32'h1000);
    chk("t4_ic_valid_cyc", first_ic(), 6);
    chk("t4_second_a", o_a[7], 32'h2003);
    chk("t4_lsb_valid_cyc", first_ls(), 9);
    chk("t4_ic_data", o_icd[6], 32'h0000_0513);
    chk("t4_lsb_rdata", o_lsd[9], 32'h0000_00F0);
`else
    chk("t4_first_a", o_a[1], 32'h2003);
    chk("t4_lsb_valid_cyc", first_ls(), 3);
    chk("t4_second_a", o_a[4], 32'h1000);
    chk("t4_last_ic_a", o_a[7], 32'h1003);
    chk("t4_ic_valid_cyc", first_ic(), 9);
    chk("t4_ic_data", o_icd[9], 32'h0000_0513);
`endif

    // Flush in cycle 2 of a fetch, with a store latched behind it.
    begin_seq();
    ic_req = 1'b1; ic_addr = 32'h1000;
    step(); idle_inputs();
    lsb_issue(1'b1, 2'b00, 32'h200, 32'h55);
    step(); idle_inputs();
    flush = 1'b1;
    step(); idle_inputs();
    repeat (5) step();
    chk("t5_no_ic_valid", cnt_ic(), 0);
    chk("t5_idle_mem_a", o_a[3], 0);
    chk("t5_store_a", o_a[4], 32'h200);
    chk("t5_store_wr", 32'(o_wr[4]), 1);
    chk("t5_store_dout", 32'(o_do[4]), 32'h55);
    chk("t5_lsb_valid_cyc", first_ls(), 5);

    // Flush in the same cycle as ic_req drops the request.
    begin_seq();
    ic_req = 1'b1; ic_addr = 32'h1000; flush = 1'b1;
    step(); idle_inputs();
    repeat (8) step();
    chk("t5b_no_ic_valid", cnt_ic(), 0);
    chk("t5b_no_access", o_a[1], 0);

    // Byte store to IO space with io_buffer_full high in cycles 0..2.
    begin_seq();
    io_buffer_full = 1'b1;
    lsb_issue(1'b1, 2'b00, 32'h0003_0000, 32'h77);
    step(); idle_inputs();
    step();
    step();
    io_buffer_full = 1'b0;
    repeat (4) step();
    for (int c = 1; c <= 3; c++) chk($sformatf("t6_held_wr_c%0d", c), 32'(o_wr[c]), 0);
    chk("t6_held_a", o_a[1], 32'h0003_0000);
    chk("t6_wr_c4", 32'(o_wr[4]), 1);
    chk("t6_dout_c4", 32'(o_do[4]), 32'h77);
    chk("t6_write_cnt", cnt_wr(), 1);
    chk("t6_valid_cyc", first_ls(), 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
